mdu_core: RTL

MDU_CORE -- requirements
Module: mdu_core

---
 rtl/mdu_core.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mdu_core.sv
// Multiply/divide unit holding the architectural HI/LO pair for the pipeline.
// Latency: MULT/MULTU/MADD/MADDU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES, MTHI/MTLO/NONE write on the accept edge.
// Backpressure: busy stalls issue upstream; a start seen while busy is dropped without any state change.
//
// Ports:
//   clk     - single clock, all state on rising edge
//   reset   - synchronous active-high reset, wins over a simultaneous start
//   start   - op issue strobe, accepted only when busy is low
//   md_op   - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, others NONE
//   rs_val  - dividend / multiplicand / MTHI-MTLO data
//   rt_val  - divisor / multiplier
//   busy    - op in flight
//   hi, lo  - architectural HI/LO registers
//
// Optional feature: define MDU_MADD_EN to build MADD/MADDU; otherwise codes 7/8 act as NONE.
// MULT_CYCLES and DIV_CYCLES are expected to be at least 1.

module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
`endif

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      res_q, res_d;

    // Products: the low 64 bits of a product of sign-extended operands are
    // the exact two's complement signed product.
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

    // Signed divide done on magnitudes so 0x80000000 / -1 is well defined
    // (magnitude 0x80000000, negated back to 0x80000000). The remainder
    // takes the sign of the dividend, the quotient truncates toward zero.
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;
    logic [31:0] qmag, rmag;
    logic [31:0] sdiv_q, sdiv_r;
    logic [31:0] udiv_q, udiv_r;
    logic        div_zero;

    assign rs_neg   = rs_val[31];
    assign rt_neg   = rt_val[31];
    assign rs_mag   = rs_neg ? (32'd0 - rs_val) : rs_val;
    assign rt_mag   = rt_neg ? (32'd0 - rt_val) : rt_val;
    assign qmag     = rs_mag / rt_mag;
    assign rmag     = rs_mag % rt_mag;
    assign sdiv_q   = (rs_neg ^ rt_neg) ? (32'd0 - qmag) : qmag;
    assign sdiv_r   = rs_neg ? (32'd0 - rmag) : rmag;
    assign udiv_q   = rs_val / rt_val;
    assign udiv_r   = rs_val % rt_val;
    assign div_zero = (rt_val == 32'd0);

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        if (busy_q) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                hi_d   = res_q[63:32];
                lo_d   = res_q[31:0];
                busy_d = 1'b0;
            end
        end else if (start) begin
            case (md_op)
                OP_MULT: begin
                    res_d  = prod_s;
                    cnt_d  = MULT_LD;
                    busy_d = 1'b1;
                end
                OP_MULTU: begin
                    res_d  = prod_u;
                    cnt_d  = MULT_LD;
                    busy_d = 1'b1;
                end
                // Divide by zero still runs the full busy period; reloading the
                // result register with the current HI/LO makes completion a
                // no-op since nothing else can write HI/LO while busy.
                OP_DIV: begin
                    res_d  = div_zero ? {hi_q, lo_q} : {sdiv_r, sdiv_q};
                    cnt_d  = DIV_LD;
                    busy_d = 1'b1;
                end
                OP_DIVU: begin
                    res_d  = div_zero ? {hi_q, lo_q} : {udiv_r, udiv_q};
                    cnt_d  = DIV_LD;
                    busy_d = 1'b1;
                end
                OP_MTHI: hi_d = rs_val;
                OP_MTLO: lo_d = rs_val;
`ifdef MDU_MADD_EN
                OP_MADD: begin
                    res_d  = {hi_q, lo_q} + prod_s;
                    cnt_d  = MULT_LD;
                    busy_d = 1'b1;
                end
                OP_MADDU: begin
                    res_d  = {hi_q, lo_q} + prod_u;
                    cnt_d  = MULT_LD;
                    busy_d = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            res_q  <= 64'd0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
